// File: rtl/turn_signal_pkg.sv
// Shared definitions for the tail-lamp turn signal sequencer.
// Holds the state encoding, the request-selection type, the three lamp
// patterns, and small helpers used by the top-level sequencer.
package turn_signal_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_L1,
    ST_L2,
    ST_L3,
    ST_R1,
    ST_R2,
    ST_R3,
    ST_HAZ_ON,
    ST_HAZ_OFF
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LEFT,
    SEL_RIGHT,
    SEL_HAZ
  } sel_t;

  // Lamp patterns, bit0 innermost lamp, bit2 outermost lamp.
  localparam logic [2:0] LAMPS_STEP1 = 3'b001;
  localparam logic [2:0] LAMPS_STEP2 = 3'b011;
  localparam logic [2:0] LAMPS_ALL   = 3'b111;
  localparam logic [2:0] LAMPS_OFF   = 3'b000;

  // Both turn switches on at once is treated as a hazard request.
  function automatic sel_t select_req(input logic haz, input logic left, input logic right);
    sel_t sel;
    if (haz || (left && right)) begin
      sel = SEL_HAZ;
    end else if (left) begin
      sel = SEL_LEFT;
    end else if (right) begin
      sel = SEL_RIGHT;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

  // Pattern on the sequencing side for a given left/right sequence state.
  function automatic logic [2:0] seq_pattern(input state_t st);
    logic [2:0] pat;
    case (st)
      ST_L1, ST_R1: pat = LAMPS_STEP1;
      ST_L2, ST_R2: pat = LAMPS_STEP2;
      ST_L3, ST_R3: pat = LAMPS_ALL;
      default:      pat = LAMPS_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/turn_signal_sequencer_sync_ff.sv
// Multi-flop synchronizer for one asynchronous single-bit input.
// Ports: clk_i clock, rst_i async active-high reset (clears every stage),
//        d_i asynchronous input, q_o synchronized output (STAGES cycles late).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/turn_signal_sequencer.sv
// Tail-lamp turn signal sequencer: left/right three-step sequences, hazard
// flashing and brake overlay, all advanced by rising edges of slow_clock.
// Ports: clock_in (only clock), reset (async active-high), slow_clock (~1 Hz
//        step source, sampled as data), left_req/right_req/hazard_req/brake
//        (async switches), left_lamps/right_lamps (registered 3-bit patterns).
module turn_signal_sequencer
  import turn_signal_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       slow_clock,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       brake,
  output logic [2:0] left_lamps,
  output logic [2:0] right_lamps
);

  logic slow_s;
  logic left_s;
  logic right_s;
  logic haz_s;
  logic brake_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_slow (
    .clk_i(clock_in), .rst_i(reset), .d_i(slow_clock), .q_o(slow_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_left (
    .clk_i(clock_in), .rst_i(reset), .d_i(left_req), .q_o(left_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_right (
    .clk_i(clock_in), .rst_i(reset), .d_i(right_req), .q_o(right_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_haz (
    .clk_i(clock_in), .rst_i(reset), .d_i(hazard_req), .q_o(haz_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_brake (
    .clk_i(clock_in), .rst_i(reset), .d_i(brake), .q_o(brake_s)
  );

  logic       slow_prev_q;
  logic       step;
  sel_t       sel;
  state_t     state_q;
  state_t     state_d;
  logic [2:0] left_lamps_q;
  logic [2:0] left_lamps_d;
  logic [2:0] right_lamps_q;
  logic [2:0] right_lamps_d;

  // Prev flop resets to 0, so a slow_clock already high at reset release
  // still yields exactly one step once it has crossed the synchronizer.
  assign step = slow_s & ~slow_prev_q;
  assign sel  = select_req(haz_s, left_s, right_s);

  always_comb begin
    state_d = state_q;
    if (step) begin
      case (state_q)
        ST_IDLE: begin
          case (sel)
            SEL_HAZ:   state_d = ST_HAZ_ON;
            SEL_LEFT:  state_d = ST_L1;
            SEL_RIGHT: state_d = ST_R1;
            default:   state_d = ST_IDLE;
          endcase
        end
        ST_L1:      state_d = (sel == SEL_LEFT)  ? ST_L2 : ST_IDLE;
        ST_L2:      state_d = (sel == SEL_LEFT)  ? ST_L3 : ST_IDLE;
        ST_R1:      state_d = (sel == SEL_RIGHT) ? ST_R2 : ST_IDLE;
        ST_R2:      state_d = (sel == SEL_RIGHT) ? ST_R3 : ST_IDLE;
        ST_HAZ_ON:  state_d = (sel == SEL_HAZ)   ? ST_HAZ_OFF : ST_IDLE;
        ST_HAZ_OFF: state_d = (sel == SEL_HAZ)   ? ST_HAZ_ON  : ST_IDLE;
        // L3/R3 always close the sequence; unused encodings recover to idle.
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Lamps are derived from the next state so they change on the same edge
  // as the state register; any side not sequencing shows brake.
  always_comb begin
    left_lamps_d  = LAMPS_OFF;
    right_lamps_d = LAMPS_OFF;
    case (state_d)
      ST_L1, ST_L2, ST_L3: begin
        left_lamps_d  = seq_pattern(state_d);
        right_lamps_d = brake_s ? LAMPS_ALL : LAMPS_OFF;
      end
      ST_R1, ST_R2, ST_R3: begin
        left_lamps_d  = brake_s ? LAMPS_ALL : LAMPS_OFF;
        right_lamps_d = seq_pattern(state_d);
      end
      ST_HAZ_ON: begin
        left_lamps_d  = LAMPS_ALL;
        right_lamps_d = LAMPS_ALL;
      end
      ST_HAZ_OFF: begin
        left_lamps_d  = LAMPS_OFF;
        right_lamps_d = LAMPS_OFF;
      end
      default: begin
        left_lamps_d  = brake_s ? LAMPS_ALL : LAMPS_OFF;
        right_lamps_d = brake_s ? LAMPS_ALL : LAMPS_OFF;
      end
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      slow_prev_q   <= 1'b0;
      state_q       <= ST_IDLE;
      left_lamps_q  <= LAMPS_OFF;
      right_lamps_q <= LAMPS_OFF;
    end else begin
      slow_prev_q   <= slow_s;
      state_q       <= state_d;
      left_lamps_q  <= left_lamps_d;
      right_lamps_q <= right_lamps_d;
    end
  end

  assign left_lamps  = left_lamps_q;
  assign right_lamps = right_lamps_q;

endmodule
